// File: rtl/ram_pkg.sv
// ram_pkg: shared types, lane width and helpers for the ram_mem_bank slice
package ram_pkg;
    typedef enum logic {CLEAR, IDLE} state_t;
    localparam int LANE_W = 8;
    function automatic logic even_par(input logic [LANE_W-1:0] b);
        return ^b;
    endfunction
    function automatic int lanes(input int dw);
        return dw / LANE_W;
    endfunction
endpackage

// File: rtl/ram_byte_lane.sv
// ram_byte_lane: one byte (or byte+parity) wide lane of the bank with optional write-first bypass
module ram_byte_lane
    import ram_pkg::*;
#(
    parameter int W       = LANE_W,
    parameter int ADDR_W  = 10,
    parameter int RD_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wd,
    output logic [W-1:0]      rdata
);
    logic [W-1:0] mem [2**ADDR_W];
    // storage array, no reset so it maps onto block RAM
    always_ff @(posedge clk)
        if (wr) mem[addr] <= wd;
    // read register holds its value between reads; write-first returns the incoming bits
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else if (rd) rdata <= (RD_MODE != 0 && wr) ? wd : mem[addr];
endmodule

// File: rtl/ram_mem_bank.sv
// ram_mem_bank: byte-lane RAM bank with clear engine and fixed-latency reads; RAM_PARITY_EN adds lane parity
module ram_mem_bank
    import ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0,
    localparam int LANES  = lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              ren,
    input  logic [LANES-1:0]  we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
`ifdef RAM_PARITY_EN
    input  logic [LANES-1:0]  par_inj,
    output logic [LANES-1:0]  par_err,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] dout,
    output logic              busy
);
`ifdef RAM_PARITY_EN
    localparam int W = LANE_W + 1;
    logic [LANES-1:0] e1;
`else
    localparam int W = LANE_W;
`endif
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              clearing, acc, rd, v1;
    logic [ADDR_W-1:0] a;
    logic [W-1:0]      q [LANES];
    logic [DATA_W-1:0] d1;

    assign clearing = state == CLEAR;
    assign acc      = req_valid & req_ready;
    assign rd       = acc & (ren | (|we));
    assign a        = clearing ? cnt : addr;

    // clear engine walks every word once, then hands the port to requests
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
        end else if (clearing) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                state     <= IDLE;
                req_ready <= 1'b1;
                busy      <= 1'b0;
            end
        end else if (clr) begin
            state     <= CLEAR;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
        end

    // first response stage tracks which cycles carry read data
    always_ff @(posedge clk or posedge rst)
        if (rst) v1 <= 1'b0;
        else v1 <= rd;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0] wd;
`ifdef RAM_PARITY_EN
        assign wd    = clearing ? '0 : {even_par(din[LANE_W*i +: LANE_W]) ^ par_inj[i], din[LANE_W*i +: LANE_W]};
        assign e1[i] = ^q[i];
`else
        assign wd    = clearing ? '0 : din[LANE_W*i +: LANE_W];
`endif
        assign d1[LANE_W*i +: LANE_W] = q[i][LANE_W-1:0];
        ram_byte_lane #(.W(W), .ADDR_W(ADDR_W), .RD_MODE(RD_MODE)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr    (clearing | (acc & we[i])),
            .rd    (rd),
            .addr  (a),
            .wd    (wd),
            .rdata (q[i])
        );
    end

    if (OUT_REG != 0) begin : g_oreg
        // extra output stage; only loads on valid so dout holds between responses
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                rsp_valid <= 1'b0;
                dout      <= '0;
            end else begin
                rsp_valid <= v1;
                if (v1) dout <= d1;
            end
`ifdef RAM_PARITY_EN
        // parity flags travel with dout
        always_ff @(posedge clk or posedge rst)
            if (rst) par_err <= '0;
            else if (v1) par_err <= e1;
`endif
    end else begin : g_nreg
        assign rsp_valid = v1;
        assign dout      = d1;
`ifdef RAM_PARITY_EN
        assign par_err   = e1;
`endif
    end
endmodule

// File: tb/tb_ram_mem_bank.sv
// tb_ram_mem_bank: random and directed checks of two bank configurations against a word-level model
module tb_ram_mem_bank;
    localparam int DEPTH = 16;
    logic        clk = 0, rst = 1, clr = 0, req_valid = 0, ren = 0;
    logic [3:0]  we = 0, addr = 0, inj = 0;
    logic [31:0] din = 0;
    logic        rdy0, rdy1, bsy0, bsy1, rv0, rv1;
    logic [31:0] do0, do1;
`ifdef RAM_PARITY_EN
    logic [3:0]  pe0, pe1;
`endif
    always #5 clk = ~clk;

    ram_mem_bank #(.DATA_W(32), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(rdy0),
        .ren(ren), .we(we), .addr(addr), .din(din),
`ifdef RAM_PARITY_EN
        .par_inj(inj), .par_err(pe0),
`endif
        .rsp_valid(rv0), .dout(do0), .busy(bsy0));

    ram_mem_bank #(.DATA_W(32), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(rdy1),
        .ren(ren), .we(we), .addr(addr), .din(din),
`ifdef RAM_PARITY_EN
        .par_inj(inj), .par_err(pe1),
`endif
        .rsp_valid(rv1), .dout(do1), .busy(bsy1));

    logic [31:0] mem [DEPTH];
    logic [3:0]  pf [DEPTH];
    int          left;
    logic        e0v, e1v, pv;
    logic [31:0] e0d, e1d, pd;
    logic [3:0]  e0e, e1e, pe;
    int          n_checks = 0, n_fail = 0, nv0 = 0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[i] ? d[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("ready0", {31'd0, rdy0}, {31'd0, left == 0});
        check("ready1", {31'd0, rdy1}, {31'd0, left == 0});
        check("busy0", {31'd0, bsy0}, {31'd0, left != 0});
        check("busy1", {31'd0, bsy1}, {31'd0, left != 0});
        check("rvalid0", {31'd0, rv0}, {31'd0, e0v});
        check("rvalid1", {31'd0, rv1}, {31'd0, e1v});
        check("dout0", do0, e0d);
        check("dout1", do1, e1d);
`ifdef RAM_PARITY_EN
        check("perr0", {28'd0, pe0}, {28'd0, e0e});
        check("perr1", {28'd0, pe1}, {28'd0, e1e});
`endif
    endtask

    task automatic model_reset();
        left = DEPTH;
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = 0;
            pf[k]  = 0;
        end
        {e0v, e1v, pv} = 0;
        {e0d, e1d, pd} = 0;
        {e0e, e1e, pe} = 0;
    endtask

    task automatic step(input logic v, input logic r, input logic [3:0] w, input logic [3:0] a,
                        input logic [31:0] d, input logic c);
        logic        acc, hit;
        logic [31:0] o, n;
        logic [3:0]  oe, ne;
        req_valid = v; ren = r; we = w; addr = a; din = d; clr = c;
        acc = v && left == 0;
        hit = acc && (r || w != 0);
        o   = mem[a];
        n   = merge(o, d, w);
        oe  = pf[a];
        ne  = (oe & ~w) | (inj & w);
        @(posedge clk);
        #1;
        e1v = pv;
        if (pv) begin
            e1d = pd;
            e1e = pe;
        end
        pv = hit;
        if (hit) begin
            pd = n;
            pe = ne;
        end
        e0v = hit;
        if (hit) begin
            e0d = o;
            e0e = oe;
        end
        if (left > 0) left--;
        else begin
            if (acc && w != 0) begin
                mem[a] = n;
                pf[a]  = ne;
            end
            if (c) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mem[k] = 0;
                    pf[k]  = 0;
                end
                left = DEPTH;
            end
        end
        compare_all();
        nv0 += int'(rv0);
        @(negedge clk);
        req_valid = 0; ren = 0; we = 0; clr = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            idle();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 0;
        wait_ready(n);
        check("clear_len", n, 16);
        for (int k = 0; k < DEPTH; k++) begin
            step(1, 1, 0, 4'(k), 0, 0);
            check("init_zero", do0, 0);
        end
        idle();
        step(1, 0, 4'hF, 3, 32'hA1B2C3D4, 0);
        step(1, 0, 4'h5, 3, 32'hFFFFFFFF, 0);
        step(1, 1, 4'h0, 3, 0, 0);
        check("lane_wr0", do0, 32'hA1FFC3FF);
        idle();
        check("lane_wr1", do1, 32'hA1FFC3FF);
        step(1, 0, 4'hF, 5, 32'h11223344, 0);
        step(1, 1, 4'h3, 5, 32'hAAAABBBB, 0);
        check("rdfirst", do0, 32'h11223344);
        idle();
        check("wrfirst", do1, 32'h1122BBBB);
        for (int k = 0; k < DEPTH; k++) step(1, 0, 4'hF, 4'(k), 32'h5A000000 + k, 0);
        nv0 = 0;
        for (int k = 0; k < DEPTH; k++) step(1, 1, 0, 4'(k), 0, 0);
        idle();
        check("stream_cnt", nv0, 16);
        step(1, 0, 0, 2, 32'h12345678, 0);
        check("noresp", {31'd0, rv0}, 0);
        step(1, 1, 0, 7, 0, 1);
        check("clr_old0", do0, 32'h5A000007);
        wait_ready(n);
        check("clr_len", n, 16);
        check("clr_old1", do1, 32'h5A000007);
        for (int k = 0; k < DEPTH; k++) begin
            step(1, 1, 0, 4'(k), 0, 0);
            check("clr_zero", do0, 0);
        end
        idle();
        step(0, 0, 0, 0, 0, 1);
        repeat (6) idle();
        do_reset();
        wait_ready(n);
        check("rst_clear_len", n, 16);
`ifdef RAM_PARITY_EN
        inj = 4'h4;
        step(1, 0, 4'hF, 2, 32'hDEADBEEF, 0);
        inj = 4'h0;
        step(1, 1, 0, 2, 0, 0);
        check("perr_inj", {28'd0, pe0}, 32'h4);
        idle();
        step(1, 0, 4'hF, 2, 32'hDEADBEEF, 0);
        step(1, 1, 0, 2, 0, 0);
        check("perr_clean", {28'd0, pe0}, 0);
        idle();
`endif
        for (int k = 0; k < 400; k++) begin
`ifdef RAM_PARITY_EN
            inj = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
`endif
            step($urandom_range(0, 3) != 0, 1'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                 4'($urandom), $urandom, $urandom_range(0, 59) == 0);
        end
        repeat (3) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
